// File: rtl/fnd_pkg.sv
// Shared definitions for the FND scan controller: digit codes, segment
// patterns and counter sizing.
package fnd_pkg;

    localparam logic [3:0] FND_BLANK = 4'd10;
    localparam logic [3:0] FND_DASH  = 4'd11;

    // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_SHOW  = 1'b1
    } phase_t;

    // Bits needed to count 0..n-1; never less than one bit
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fnd_scan_ctrl_if.sv
// Display-side bundle of the scan controller: digit codes and update strobe
// in, common/segment drives and frame pulse out.
interface fnd_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] i_digits;
    logic [NUM_DIGITS-1:0]   i_dp;
    logic                    i_lz_en;
    logic                    i_update;
    logic [NUM_DIGITS-1:0]   o_com;
    logic [7:0]              o_seg;
    logic                    o_frame;

    modport master (
        output i_digits, i_dp, i_lz_en, i_update,
        input  o_com, o_seg, o_frame
    );

    modport slave (
        input  i_digits, i_dp, i_lz_en, i_update,
        output o_com, o_seg, o_frame
    );
endinterface

// File: rtl/fnd_seg_decoder.sv
// Combinational 4-bit digit code to active-high 7-segment pattern.
// Codes 10 and 12-15 are blank; 11 is a dash.
module fnd_seg_decoder
    import fnd_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    // Table lookup; anything unlisted falls through to all segments off
    always_comb begin
        seg = 7'h00;
        case (code)
            4'd0:     seg = SEG_0;
            4'd1:     seg = SEG_1;
            4'd2:     seg = SEG_2;
            4'd3:     seg = SEG_3;
            4'd4:     seg = SEG_4;
            4'd5:     seg = SEG_5;
            4'd6:     seg = SEG_6;
            4'd7:     seg = SEG_7;
            4'd8:     seg = SEG_8;
            4'd9:     seg = SEG_9;
            FND_DASH: seg = SEG_DASH;
            default:  seg = 7'h00;
        endcase
    end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// Time-multiplexed FND scan controller. Each digit slot starts with a dead
// (all-off) period to avoid ghosting, then drives one common line. Display
// data is double-buffered and only swapped at the frame wrap so a frame never
// mixes old and new digits.
module fnd_scan_ctrl
    import fnd_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int SLOT_CYCLES = 12500,
    parameter int DEAD_CYCLES = 500,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    fnd_scan_ctrl_if.slave  bus
);

    localparam int SLOT_W = cnt_width(SLOT_CYCLES);
    localparam int IDX_W  = cnt_width(NUM_DIGITS);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_CYCLES - 1);
    localparam logic [SLOT_W-1:0] DEAD_END  = SLOT_W'(DEAD_CYCLES);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam bit                INV       = (ACTIVE_LOW != 0);

    logic [SLOT_W-1:0]       slot_cnt;
    logic [IDX_W-1:0]        idx;
    logic                    slot_wrap;
    logic                    frame_wrap;
    phase_t                  phase;

    logic [4*NUM_DIGITS-1:0] pend_digits;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic                    pend_lz;
    logic                    pend_flag;
    logic [4*NUM_DIGITS-1:0] shadow_digits;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic                    shadow_lz;

    logic [NUM_DIGITS-1:0]   supp;
    logic [3:0]              cur_code;
    logic [6:0]              cur_pat;
    logic [NUM_DIGITS-1:0]   com_act;
    logic [7:0]              seg_act;

    logic [NUM_DIGITS-1:0]   com_q;
    logic [7:0]              seg_q;
    logic                    frame_q;

    assign slot_wrap  = (slot_cnt == SLOT_LAST);
    assign frame_wrap = slot_wrap && (idx == IDX_LAST);
    assign phase      = (slot_cnt < DEAD_END) ? PH_BLANK : PH_SHOW;

    // Slot counter and digit index advance
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            slot_cnt <= '0;
            idx      <= '0;
        end else begin
            slot_cnt <= slot_wrap ? '0 : slot_cnt + 1'b1;
            if (slot_wrap) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end
        end
    end

    // Pending capture on strobe; shadow swap only at frame wrap (a strobe on
    // the wrap cycle itself bypasses pending and lands in shadow directly)
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pend_digits   <= '0;
            pend_dp       <= '0;
            pend_lz       <= 1'b0;
            pend_flag     <= 1'b0;
            shadow_digits <= {NUM_DIGITS{FND_BLANK}};
            shadow_dp     <= '0;
            shadow_lz     <= 1'b0;
        end else begin
            if (bus.i_update) begin
                pend_digits <= bus.i_digits;
                pend_dp     <= bus.i_dp;
                pend_lz     <= bus.i_lz_en;
            end
            if (frame_wrap) begin
                pend_flag <= 1'b0;
                if (bus.i_update) begin
                    shadow_digits <= bus.i_digits;
                    shadow_dp     <= bus.i_dp;
                    shadow_lz     <= bus.i_lz_en;
                end else if (pend_flag) begin
                    shadow_digits <= pend_digits;
                    shadow_dp     <= pend_dp;
                    shadow_lz     <= pend_lz;
                end
            end else if (bus.i_update) begin
                pend_flag <= 1'b1;
            end
        end
    end

    // Leading-zero mask: digit k>=1 blanks when it and every higher digit is 0
    always_comb begin
        logic run;
        run  = 1'b1;
        supp = '0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            run     = run & (shadow_digits[4*k +: 4] == 4'd0);
            supp[k] = run & shadow_lz;
        end
    end

    assign cur_code = supp[idx] ? FND_BLANK : shadow_digits[{idx, 2'b00} +: 4];

    fnd_seg_decoder u_dec (
        .code (cur_code),
        .seg  (cur_pat)
    );

    // Active-high drive for the current slot; all off during dead time
    always_comb begin
        com_act = '0;
        seg_act = '0;
        if (phase == PH_SHOW) begin
            com_act[idx] = 1'b1;
            seg_act      = {shadow_dp[idx], cur_pat};
        end
    end

    // Output registers with polarity applied at the pins
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            com_q   <= INV ? '1 : '0;
            seg_q   <= INV ? '1 : '0;
            frame_q <= 1'b0;
        end else begin
            com_q   <= INV ? ~com_act : com_act;
            seg_q   <= INV ? ~seg_act : seg_act;
            frame_q <= frame_wrap;
        end
    end

    assign bus.o_com   = com_q;
    assign bus.o_seg   = seg_q;
    assign bus.o_frame = frame_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Bench for fnd_scan_ctrl: cycle-accurate reference model checked on every
// clock, a table of display vectors, and hand sequences for buffering and reset.
module tb_fnd_scan_ctrl;

    localparam int N = 4;
    localparam int S = 5;
    localparam int D = 1;
    localparam int F = S * N;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    fnd_scan_ctrl_if #(.NUM_DIGITS(N)) bus ();

    fnd_scan_ctrl #(
        .NUM_DIGITS  (N),
        .SLOT_CYCLES (S),
        .DEAD_CYCLES (D),
        .ACTIVE_LOW  (1)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: position in time since reset, plus displayed/pending data
    int         m_p;
    logic [3:0] m_code [N];
    logic [N-1:0] m_dp;
    logic       m_lz;
    logic [3:0] p_code [N];
    logic [N-1:0] p_dp;
    logic       p_lz;
    bit         p_valid;
    logic [3:0] e_com;
    logic [7:0] e_seg;
    logic       e_frame;

    typedef struct {
        logic [15:0]     digits;
        logic [3:0]      dp;
        logic            lz;
        logic [3:0][7:0] exp;
    } vec_t;

    vec_t vecs [6];

    function automatic logic [6:0] ref_pat(input logic [3:0] c);
        case (c)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            4'd11: return 7'h40;
            default: return 7'h00;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_p = 0;
        for (int k = 0; k < N; k++) begin
            m_code[k] = 4'd10;
            p_code[k] = 4'd0;
        end
        m_dp    = '0;
        m_lz    = 1'b0;
        p_dp    = '0;
        p_lz    = 1'b0;
        p_valid = 1'b0;
    endtask

    task automatic model_edge();
        int cnt;
        int idx;
        logic [3:0] code;
        bit allz;
        if (rst) begin
            e_com   = 4'hF;
            e_seg   = 8'hFF;
            e_frame = 1'b0;
            model_reset();
            return;
        end
        cnt = m_p % S;
        idx = (m_p / S) % N;
        if (cnt < D) begin
            e_com = 4'hF;
            e_seg = 8'hFF;
        end else begin
            code = m_code[idx];
            allz = 1'b1;
            for (int k = idx; k < N; k++) if (m_code[k] != 4'd0) allz = 1'b0;
            if (m_lz && idx >= 1 && allz) code = 4'd10;
            e_com = ~(4'b0001 << idx);
            e_seg = ~{m_dp[idx], ref_pat(code)};
        end
        e_frame = ((m_p % F) == F - 1);
        if (e_frame) begin
            if (bus.i_update) begin
                for (int k = 0; k < N; k++) m_code[k] = bus.i_digits[4*k +: 4];
                m_dp = bus.i_dp;
                m_lz = bus.i_lz_en;
            end else if (p_valid) begin
                for (int k = 0; k < N; k++) m_code[k] = p_code[k];
                m_dp = p_dp;
                m_lz = p_lz;
            end
            p_valid = 1'b0;
        end else if (bus.i_update) begin
            for (int k = 0; k < N; k++) p_code[k] = bus.i_digits[4*k +: 4];
            p_dp    = bus.i_dp;
            p_lz    = bus.i_lz_en;
            p_valid = 1'b1;
        end
        m_p++;
    endtask

    task automatic tick(input bit upd);
        bus.i_update = upd;
        @(posedge clk);
        model_edge();
        #1;
        bus.i_update = 1'b0;
        check("model_com", bus.o_com, e_com);
        check("model_seg", bus.o_seg, e_seg);
        check("model_frame", bus.o_frame, e_frame);
    endtask

    task automatic load(input logic [15:0] d, input logic [3:0] dp, input logic lz);
        bus.i_digits = d;
        bus.i_dp     = dp;
        bus.i_lz_en  = lz;
        tick(1'b1);
    endtask

    task automatic wait_frame();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 3 * F && !seen; i++) begin
            tick(1'b0);
            if (bus.o_frame === 1'b1) seen = 1'b1;
        end
        check("frame_timeout", seen, 1);
    endtask

    // One full frame right after an observed o_frame pulse
    task automatic frame_check(input string name, input logic [3:0][7:0] exp);
        logic [3:0] ecom;
        for (int t = 0; t < F; t++) begin
            tick(1'b0);
            if ((t % S) >= D) begin
                ecom = 4'hF ^ (4'b0001 << (t / S));
                check({name, "_com"}, bus.o_com, ecom);
                check({name, "_seg"}, bus.o_seg, exp[t / S]);
            end else begin
                check({name, "_dead"}, {bus.o_com, bus.o_seg}, 12'hFFF);
            end
            check({name, "_period"}, bus.o_frame, (t == F - 1));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{16'h4321, 4'b0000, 1'b0, {8'h99, 8'hB0, 8'hA4, 8'hF9}};
        vecs[1] = '{16'h0005, 4'b0000, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'h92}};
        vecs[2] = '{16'h0105, 4'b0000, 1'b1, {8'hFF, 8'hF9, 8'hC0, 8'h92}};
        vecs[3] = '{16'h0B00, 4'b0001, 1'b0, {8'hC0, 8'hBF, 8'hC0, 8'h40}};
        vecs[4] = '{16'h0000, 4'b1010, 1'b1, {8'h7F, 8'hFF, 8'h7F, 8'hC0}};
        vecs[5] = '{16'hFCA7, 4'b0000, 1'b0, {8'hFF, 8'hFF, 8'hFF, 8'hF8}};

        bus.i_digits = '0;
        bus.i_dp     = '0;
        bus.i_lz_en  = 1'b0;
        bus.i_update = 1'b0;
        model_reset();

        // Reset held three clocks, then scan start
        rst = 1'b1;
        repeat (3) tick(1'b0);
        check("reset_com", bus.o_com, 4'hF);
        check("reset_seg", bus.o_seg, 8'hFF);
        rst = 1'b0;
        tick(1'b0);
        check("first_blank", {bus.o_com, bus.o_seg}, 12'hFFF);
        tick(1'b0);
        check("first_show_com", bus.o_com, 4'b1110);
        check("first_show_seg", bus.o_seg, 8'hFF);

        // Table of display vectors
        for (int v = 0; v < 6; v++) begin
            load(vecs[v].digits, vecs[v].dp, vecs[v].lz);
            wait_frame();
            frame_check($sformatf("vec%0d", v), vecs[v].exp);
        end

        // Two strobes within one frame: only the last appears, after the wrap
        repeat (3) tick(1'b0);
        load(16'h0012, 4'b0000, 1'b0);
        repeat (2) tick(1'b0);
        load(16'h0099, 4'b0000, 1'b0);
        wait_frame();
        frame_check("last_wins", {8'hC0, 8'hC0, 8'h90, 8'h90});

        // Reset while digit 2 is lit
        repeat (12) tick(1'b0);
        check("pre_rst_idx2", bus.o_com, 4'b1011);
        rst = 1'b1;
        tick(1'b0);
        check("mid_rst_com", bus.o_com, 4'hF);
        check("mid_rst_seg", bus.o_seg, 8'hFF);
        rst = 1'b0;
        tick(1'b0);
        check("post_rst_blank", {bus.o_com, bus.o_seg}, 12'hFFF);
        tick(1'b0);
        check("post_rst_com", bus.o_com, 4'b1110);
        check("post_rst_seg", bus.o_seg, 8'hFF);

        // Randomized traffic against the model, including occasional resets
        for (int i = 0; i < 1500; i++) begin
            bus.i_digits = 16'($urandom);
            bus.i_dp     = 4'($urandom);
            bus.i_lz_en  = 1'($urandom);
            rst          = ($urandom_range(0, 399) == 0);
            tick($urandom_range(0, 7) == 0);
        end
        rst = 1'b0;
        repeat (2 * F) tick(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
